instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Program sequencer that sits directly upstream of the multicycle processor core and owns the core's DIN and Run inputs.
- Holds a small loadable program memory and a program counter.
- Issues one instruction per core T0 and supplies the immediate word in the step where the core samples DIN.
- Waits for the core's Done, advances the PC, and stops on a HALT opcode, a stop request, or a watchdog fault.

Parameters:
- ADDR_W, 6, program-memory address width; DEPTH = 2**ADDR_W words of 9 bits.
- WDOG_MAX, 3, maximum cycles in EXEC without Done before a fault is raised.

Ports:
- Clock  input  1  system clock; all state changes on the rising edge.
- Resetn  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle pulse; begins execution at address 0 when idle.
- Stop  input  1  request to finish the current instruction, then go idle.
- LoadEn  input  1  program-memory write enable, honoured only when idle.
- LoadAddr  input  ADDR_W  write address.
- LoadData  input  9  write data (III XXX YYY, or a raw immediate).
- Done  input  1  core Done, combinational from the core.
- DIN  output  9  word driven to the core's DIN.
- Run  output  1  core Run.
- PC  output  ADDR_W  address of the current or next instruction.
- Busy  output  1  high in ISSUE and EXEC.
- Halted  output  1  sticky; set by the HALT opcode.
- Fault  output  1  sticky; set by watchdog expiry.
- RetCount  output  16  instructions retired, saturating at 0xFFFF.

Behaviour:
- Reset (asynchronous, Resetn=0): state IDLE, PC=0, DIN=0, Run=0, Busy=0, Halted=0, Fault=0, RetCount=0, watchdog=0. Memory contents are not reset. Reset mid-instruction abandons that instruction immediately.
- Opcode classes: IMM1 = {001 MVI, 101 MVIALL}, immediate sampled by the core in T1. IMM2 = {100 ADDI}, immediate sampled in T2. HALT = 111. All other opcodes have no immediate.
- IDLE:
  - DIN=0, Run=0.
  - LoadEn writes mem[LoadAddr]=LoadData on the edge.
  - Start clears Halted, Fault and RetCount, sets PC=0 and moves to ISSUE.
  - Start and LoadEn asserted together: the write happens and Start also takes effect.
- ISSUE (core in T0):
  - DIN=mem[PC] combinationally.
  - If the opcode is HALT: Run=0; next state IDLE, Halted=1, PC held at the HALT address.
  - Otherwise: Run=1; next state EXEC; latch the opcode; watchdog=0.
  - Stop sampled high in ISSUE: go to IDLE without issuing (Run=0 that cycle).
- EXEC (core in T1..T3):
  - Run=0.
  - DIN=mem[(PC+1) mod DEPTH] in the first EXEC cycle when IMM1, and in the second EXEC cycle when IMM2; otherwise DIN=0.
  - On a cycle with Done=1: PC += 2 for IMM1 or IMM2, else PC += 1, modulo DEPTH (wrap-around; an immediate at DEPTH-1 reads address 0); RetCount increments (saturating).
  - After Done, next state is ISSUE, or IDLE if Stop was seen at any point during ISSUE or EXEC for this instruction. There is no bubble between back-to-back instructions.
  - Watchdog increments every EXEC cycle without Done. When it reaches WDOG_MAX, the next edge goes to IDLE with Fault=1 and PC unchanged.
- Start while Busy is ignored. LoadEn while Busy is ignored (no write).
- Latency per instruction, first Run to next Run: MV/MVI/MVIALL 2 cycles, ADD/SUB/ADDI 4 cycles.

Test Plan:
- Load mem[0..2] = 0x040, 0x005, 0x1C0 (MVI R0,5; imm; HALT); pulse Start -> Run high for one cycle with DIN=0x040, next cycle DIN=0x005 with Done=1; R0=5; then Halted=1, PC=2, RetCount=1, Busy=0.
- Program MVI R1,3 (0x048, 0x003); ADDI R1,R1 with imm 4 (0x109, 0x004); HALT -> ADDI immediate 0x004 appears on DIN only in the second EXEC cycle; R1=7; PC ends at 4.
- MV R1,R0 (0x008) followed by ADD R0,R1 (0x081) -> PC advances by 1 each; Run pulses are 2 cycles apart, then 4 cycles; RetCount=2.
- Tie Done=0 after a Run pulse -> Fault=1 after 3 EXEC cycles; state IDLE; PC unchanged; Start clears Fault.
- Place MVI at address DEPTH-1 with its immediate at address 0 -> DIN shows mem[0] in T1; PC wraps to 1.
- Pulse Resetn low during EXEC of an ADD -> Run=0, DIN=0, PC=0 immediately; memory retained; a subsequent Start re-executes from address 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Program sequencer that sits directly in front of the multicycle core and
//   owns the core's DIN and Run inputs. It holds a small loadable program
//   memory and a program counter. It issues one instruction per core T0 and
//   presents the immediate word in the step where the core samples DIN. It then
//   waits for Done, advances the PC, and stops on HALT, on a stop request, or
//   when the watchdog expires.
//
//   Handshake: Run is a one-cycle issue strobe, high only in ISSUE. Done is
//   combinational from the core. It is sampled on the rising edge during EXEC
//   and retires the instruction that is in flight.
//
// Ports
//   Clock, Resetn      : clock, asynchronous active-low reset
//   Start              : one-cycle pulse, begins execution at address 0 (idle only)
//   Stop               : finish the current instruction, then go idle
//   LoadEn/Addr/Data   : program-memory write port (idle only)
//   Done               : core Done
//   DIN, Run           : word and run strobe driven to the core
//   PC                 : address of the current or next instruction
//   Busy               : high in ISSUE and EXEC
//   Halted, Fault      : sticky status (HALT opcode / watchdog expiry)
//   RetCount           : retired instructions, saturating at 0xFFFF

module instr_fetch_unit #(
    parameter int ADDR_W   = 6,
    parameter int WDOG_MAX = 3
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [8:0]        LoadData,
    input  logic              Done,
    output logic [8:0]        DIN,
    output logic              Run,
    output logic [ADDR_W-1:0] PC,
    output logic              Busy,
    output logic              Halted,
    output logic              Fault,
    output logic [15:0]       RetCount
);

    localparam int DEPTH = 1 << ADDR_W;
    // The watchdog only needs to count up to WDOG_MAX-1. Reaching WDOG_MAX
    // is the fault edge itself.
    localparam int WD_W  = (WDOG_MAX > 1) ? $clog2(WDOG_MAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t            state, state_nx;
    logic [8:0]        mem [DEPTH];
    logic [ADDR_W-1:0] pc_q;
    logic [WD_W-1:0]   wdog_q;     // also serves as the EXEC cycle index
    logic              imm1_q, imm2_q;
    logic              stop_seen_q;
    logic              halted_q, fault_q;
    logic [15:0]       ret_q;

    logic [8:0]        cur_word, imm_word;
    logic [2:0]        cur_op;
    logic              is_halt, is_imm1, is_imm2;

    logic              start_go, do_issue, do_halt, do_retire, do_fault, wd_inc;
    logic [8:0]        din_c;
    logic              run_c;

    assign cur_word = mem[pc_q];
    assign imm_word = mem[pc_q + ADDR_W'(1)];   // wraps naturally at DEPTH-1
    assign cur_op   = cur_word[8:6];
    assign is_halt  = (cur_op == 3'b111);
    assign is_imm1  = (cur_op == 3'b001) || (cur_op == 3'b101);
    assign is_imm2  = (cur_op == 3'b100);

    // Next-state and output decode
    always_comb begin
        state_nx  = state;
        din_c     = 9'd0;
        run_c     = 1'b0;
        start_go  = 1'b0;
        do_issue  = 1'b0;
        do_halt   = 1'b0;
        do_retire = 1'b0;
        do_fault  = 1'b0;
        wd_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    start_go = 1'b1;
                    state_nx = S_ISSUE;
                end
            end
            S_ISSUE: begin
                din_c = cur_word;
                if (is_halt) begin
                    do_halt  = 1'b1;
                    state_nx = S_IDLE;
                end else if (Stop) begin
                    state_nx = S_IDLE;
                end else begin
                    run_c    = 1'b1;
                    do_issue = 1'b1;
                    state_nx = S_EXEC;
                end
            end
            S_EXEC: begin
                // The core samples an IMM1 immediate in T1 and an IMM2 immediate in T2.
                if ((imm1_q && wdog_q == WD_W'(0)) || (imm2_q && wdog_q == WD_W'(1)))
                    din_c = imm_word;
                if (Done) begin
                    do_retire = 1'b1;
                    state_nx  = (stop_seen_q || Stop) ? S_IDLE : S_ISSUE;
                end else if (wdog_q == WD_W'(WDOG_MAX - 1)) begin
                    do_fault = 1'b1;
                    state_nx = S_IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state       <= S_IDLE;
            pc_q        <= '0;
            wdog_q      <= '0;
            imm1_q      <= 1'b0;
            imm2_q      <= 1'b0;
            stop_seen_q <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            ret_q       <= 16'd0;
        end else begin
            state <= state_nx;
            if (start_go) begin
                pc_q     <= '0;
                halted_q <= 1'b0;
                fault_q  <= 1'b0;
                ret_q    <= 16'd0;
            end
            if (do_halt)
                halted_q <= 1'b1;
            if (do_issue) begin
                imm1_q      <= is_imm1;
                imm2_q      <= is_imm2;
                wdog_q      <= '0;
                stop_seen_q <= 1'b0;
            end
            if (wd_inc)
                wdog_q <= wdog_q + WD_W'(1);
            if (state == S_EXEC && Stop)
                stop_seen_q <= 1'b1;
            if (do_retire) begin
                pc_q <= pc_q + ((imm1_q || imm2_q) ? ADDR_W'(2) : ADDR_W'(1));
                if (ret_q != 16'hFFFF)
                    ret_q <= ret_q + 16'd1;
            end
            if (do_fault)
                fault_q <= 1'b1;
        end
    end

    // Program memory is deliberately not reset, so a reset keeps the loaded program.
    always_ff @(posedge Clock) begin
        if (state == S_IDLE && LoadEn)
            mem[LoadAddr] <= LoadData;
    end

    assign DIN      = din_c;
    assign Run      = run_c;
    assign PC       = pc_q;
    assign Busy     = (state != S_IDLE);
    assign Halted   = halted_q;
    assign Fault    = fault_q;
    assign RetCount = ret_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. A small core model answers Run with Done after
// an opcode-dependent number of steps and records issued words and sampled
// immediates. Directed tables, corner sequences and random programs are
// checked against expectations computed by walking the program image.

module tb_instr_fetch_unit;

    localparam int DEPTH = 64;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       Start = 1'b0;
    logic       Stop = 1'b0;
    logic       LoadEn = 1'b0;
    logic [5:0] LoadAddr = 6'd0;
    logic [8:0] LoadData = 9'd0;
    logic       Done;
    logic [8:0] DIN;
    logic       Run;
    logic [5:0] PC;
    logic       Busy;
    logic       Halted;
    logic       Fault;
    logic [15:0] RetCount;

    instr_fetch_unit #(.ADDR_W(6), .WDOG_MAX(3)) dut (
        .Clock(Clock), .Resetn(Resetn), .Start(Start), .Stop(Stop),
        .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .Done(Done),
        .DIN(DIN), .Run(Run), .PC(PC), .Busy(Busy), .Halted(Halted),
        .Fault(Fault), .RetCount(RetCount)
    );

    // ---------------- clock / reset ----------------
    always #5 Clock = ~Clock;

    initial begin
        #300000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1);
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad = 0;
    int busy_cnt = 0;
    bit core_hang = 1'b0;
    bit cm_act = 1'b0;
    int cm_idx = 0;
    logic [2:0] cm_op = 3'd0;
    logic [8:0] got_issue[$];
    logic [8:0] got_imm[$];
    logic [8:0] exp_q[$];
    logic [8:0] exp_imm_q[$];
    logic [8:0] img [DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Core behaviour: EXEC steps per opcode class and where immediates are sampled.
    function automatic int lat_of(input logic [2:0] op);
        return (op == 3'b010 || op == 3'b011 || op == 3'b100) ? 3 : 1;
    endfunction

    function automatic int imm_len(input logic [2:0] op);
        return (op == 3'b001 || op == 3'b101 || op == 3'b100) ? 1 : 0;
    endfunction

    function automatic bit imm_at(input logic [2:0] op, input int idx);
        return ((op == 3'b001 || op == 3'b101) && idx == 0) || (op == 3'b100 && idx == 1);
    endfunction

    // ---------------- core model ----------------
    initial begin
        Done = 1'b0;
        forever begin
            @(negedge Clock);
            if (!Resetn || !Busy) begin
                cm_act = 1'b0;
                Done = 1'b0;
            end else begin
                busy_cnt++;
                if (Run) begin
                    got_issue.push_back(DIN);
                    cm_op = DIN[8:6];
                    cm_idx = 0;
                    cm_act = 1'b1;
                    Done = 1'b0;
                end else if (cm_act) begin
                    if (imm_at(cm_op, cm_idx))
                        got_imm.push_back(DIN);
                    else
                        check("exec_din_zero", 32'(DIN), 32'd0);
                    Done = !core_hang && (cm_idx == lat_of(cm_op) - 1);
                    if (Done) cm_act = 1'b0;
                    cm_idx++;
                end else begin
                    Done = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks (called at a negedge) ----------------
    task automatic load_word(input logic [5:0] a, input logic [8:0] d);
        LoadEn = 1'b1;
        LoadAddr = a;
        LoadData = d;
        @(negedge Clock);
        LoadEn = 1'b0;
    endtask

    task automatic load_image();
        for (int i = 0; i < DEPTH; i++) load_word(6'(i), img[i]);
    endtask

    task automatic clear_obs();
        busy_cnt = 0;
        got_issue.delete();
        got_imm.delete();
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (Busy && n < 3000) begin
            @(negedge Clock);
            n++;
        end
        check({tag, "_timeout"}, 32'(Busy), 32'd0);
    endtask

    // poke: while busy, try a write over the HALT at address 2 plus a Start.
    task automatic run_prog(input bit poke, input string tag);
        clear_obs();
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        if (poke) begin
            @(negedge Clock);
            Start = 1'b1;
            LoadEn = 1'b1;
            LoadAddr = 6'd2;
            LoadData = 9'h000;
            @(negedge Clock);
            Start = 1'b0;
            LoadEn = 1'b0;
        end
        wait_idle(tag);
    endtask

    task automatic check_end(input string tag, input logic [5:0] pc, input logic [15:0] ret,
                             input logic h, input logic f, input int b);
        check({tag, "_pc"}, 32'(PC), 32'(pc));
        check({tag, "_ret"}, 32'(RetCount), 32'(ret));
        check({tag, "_halted"}, 32'(Halted), 32'(h));
        check({tag, "_fault"}, 32'(Fault), 32'(f));
        check({tag, "_busycycles"}, 32'(busy_cnt), 32'(b));
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [5:0][8:0] prog;
        int              len;
        logic [5:0]      pc;
        logic [15:0]     ret;
        int              busy;
        int              nimm;
        logic [8:0]      imm;
    } vec_t;

    vec_t vt[5];

    initial begin
        int rpc, rcnt, rbc, a, k;
        logic [2:0] op;

        vt[0] = '{prog: {9'h0, 9'h0, 9'h0, 9'h1C0, 9'h005, 9'h040},
                  len: 3, pc: 6'd2, ret: 16'd1, busy: 3, nimm: 1, imm: 9'h005};
        vt[1] = '{prog: {9'h0, 9'h1C0, 9'h004, 9'h109, 9'h003, 9'h048},
                  len: 5, pc: 6'd4, ret: 16'd2, busy: 7, nimm: 2, imm: 9'h004};
        vt[2] = '{prog: {9'h0, 9'h0, 9'h0, 9'h1C0, 9'h081, 9'h008},
                  len: 3, pc: 6'd2, ret: 16'd2, busy: 7, nimm: 0, imm: 9'h000};
        vt[3] = '{prog: {9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h1C0},
                  len: 1, pc: 6'd0, ret: 16'd0, busy: 1, nimm: 0, imm: 9'h000};
        vt[4] = '{prog: {9'h0, 9'h0, 9'h1C0, 9'h0FF, 9'h148, 9'h0C1},
                  len: 4, pc: 6'd3, ret: 16'd2, busy: 7, nimm: 1, imm: 9'h0FF};

        // reset state
        repeat (2) @(negedge Clock);
        check("rst_run", 32'(Run), 32'd0);
        check("rst_din", 32'(DIN), 32'd0);
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_fault", 32'(Fault), 32'd0);
        check("rst_ret", 32'(RetCount), 32'd0);
        Resetn = 1'b1;
        @(negedge Clock);

        // table-driven programs
        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < vt[v].len; i++) load_word(6'(i), vt[v].prog[i]);
            run_prog(1'b0, "tbl");
            check_end("tbl", vt[v].pc, vt[v].ret, 1'b1, 1'b0, vt[v].busy);
            check("tbl_issued", 32'(got_issue.size()), 32'(vt[v].ret));
            check("tbl_nimm", 32'(got_imm.size()), 32'(vt[v].nimm));
            if (vt[v].nimm > 0 && got_imm.size() > 0)
                check("tbl_imm", 32'(got_imm[$]), 32'(vt[v].imm));
        end

        // watchdog: core never answers an ADD
        load_word(6'd0, 9'h080);
        load_word(6'd1, 9'h1C0);
        core_hang = 1'b1;
        run_prog(1'b0, "wdog");
        check_end("wdog", 6'd0, 16'd0, 1'b0, 1'b1, 4);
        core_hang = 1'b0;
        run_prog(1'b0, "wdog_clr");
        check_end("wdog_clr", 6'd1, 16'd1, 1'b1, 1'b0, 5);

        // wrap-around: MVI at DEPTH-1 takes its immediate from address 0
        img[0] = 9'h007;
        for (int i = 1; i < DEPTH - 1; i++) img[i] = 9'h000;
        img[DEPTH-1] = 9'h040;
        load_image();
        clear_obs();
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int n = 0; n < 400 && !(Run && PC == 6'd63); n++) @(negedge Clock);
        check("wrap_reach63", 32'(Run && PC == 6'd63), 32'd1);
        @(negedge Clock);
        Stop = 1'b1;
        wait_idle("wrap");
        Stop = 1'b0;
        check_end("wrap", 6'd1, 16'd64, 1'b0, 1'b0, 128);
        check("wrap_nimm", 32'(got_imm.size()), 32'd1);
        if (got_imm.size() > 0) check("wrap_imm", 32'(got_imm[0]), 32'h007);

        // reset in the middle of an ADD, then rerun with ignored Start/LoadEn
        load_word(6'd0, 9'h008);
        load_word(6'd1, 9'h081);
        load_word(6'd2, 9'h1C0);
        clear_obs();
        Start = 1'b1;
        @(negedge Clock);
        Start = 1'b0;
        for (int n = 0; n < 20 && !(Run && PC == 6'd1); n++) @(negedge Clock);
        check("rst_mid_reach", 32'(Run && PC == 6'd1), 32'd1);
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1;
        check("rst_mid_run", 32'(Run), 32'd0);
        check("rst_mid_din", 32'(DIN), 32'd0);
        check("rst_mid_pc", 32'(PC), 32'd0);
        check("rst_mid_busy", 32'(Busy), 32'd0);
        @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);
        run_prog(1'b1, "rerun");
        check_end("rerun", 6'd2, 16'd2, 1'b1, 1'b0, 7);
        check("rerun_issued", 32'(got_issue.size()), 32'd2);
        if (got_issue.size() > 0) check("rerun_first", 32'(got_issue[0]), 32'h008);

        // random programs against a program-walk reference
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < DEPTH; i++) img[i] = 9'($urandom);
            a = 0;
            k = int'($urandom_range(4, 20));
            for (int j = 0; j < k; j++) begin
                op = 3'($urandom_range(0, 6));
                img[a] = {op, 6'($urandom)};
                a++;
                if (imm_len(op) != 0) begin
                    img[a] = 9'($urandom);
                    a++;
                end
            end
            img[a] = {3'b111, 6'($urandom)};

            exp_q.delete();
            exp_imm_q.delete();
            rpc = 0;
            rcnt = 0;
            rbc = 0;
            while (img[rpc][8:6] != 3'b111 && rcnt < 100) begin
                exp_q.push_back(img[rpc]);
                if (imm_len(img[rpc][8:6]) != 0) exp_imm_q.push_back(img[(rpc + 1) % DEPTH]);
                rbc += 1 + lat_of(img[rpc][8:6]);
                rpc = (rpc + 1 + imm_len(img[rpc][8:6])) % DEPTH;
                rcnt++;
            end
            rbc += 1;

            load_image();
            run_prog(1'b0, "rand");
            check_end("rand", 6'(rpc), 16'(rcnt), 1'b1, 1'b0, rbc);
            check("rand_issue_n", 32'(got_issue.size()), 32'(exp_q.size()));
            for (int i = 0; i < exp_q.size() && i < got_issue.size(); i++)
                check("rand_issue", 32'(got_issue[i]), 32'(exp_q[i]));
            check("rand_imm_n", 32'(got_imm.size()), 32'(exp_imm_q.size()));
            for (int i = 0; i < exp_imm_q.size() && i < got_imm.size(); i++)
                check("rand_imm", 32'(got_imm[i]), 32'(exp_imm_q[i]));
        end

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
